video_timing_gen: RTL



---
 rtl/video_timing_gen.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator (hsync/vsync/de/x/y) gated by PLL lock qualification.
// Optional macro VIDEO_TIMING_GEN_PREFETCH_EN adds o_req/o_nx/o_ny, leading o_de/o_x/o_y by one cycle.
module video_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int H_POL       = 0,
  parameter int V_POL       = 0,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_lock,
  input  logic        i_en,
  output logic        o_run,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic [10:0] o_x,
  output logic [10:0] o_y,
  output logic        o_sof,
`ifdef VIDEO_TIMING_GEN_PREFETCH_EN
  output logic        o_req,
  output logic [10:0] o_nx,
  output logic [10:0] o_ny,
`endif
  output logic        o_sol
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int LW      = $clog2(LOCK_CYCLES + 1);

  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_size_check
    $error("video_timing_gen: H_TOTAL/V_TOTAL must not exceed 2048");
  end

  // 12-bit bounds so a boundary equal to 2048 does not alias to zero
  localparam logic [11:0] H_ACT_C  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG_C = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END_C = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT_C  = 12'(V_ACTIVE);
  localparam logic [11:0] VS_BEG_C = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END_C = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
  localparam logic HP = (H_POL != 0);
  localparam logic VP = (V_POL != 0);

  typedef enum logic [1:0] {WAIT_LOCK, IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic          lock_meta, lock_s;
  logic [LW-1:0] lock_cnt, lock_cnt_nxt;
  logic [10:0]   h, v, h_nxt, v_nxt;
  logic          h_last, v_last;
  logic          run_nxt, de_nxt, hs_act, vs_act, sof_nxt, sol_nxt;

  assign h_last = (h == H_LAST);
  assign v_last = (v == V_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      state     <= WAIT_LOCK;
      lock_cnt  <= '0;
      h         <= '0;
      v         <= '0;
    end else begin
      lock_meta <= i_lock;
      lock_s    <= lock_meta;
      state     <= state_nxt;
      lock_cnt  <= lock_cnt_nxt;
      h         <= h_nxt;
      v         <= v_nxt;
    end
  end

  // Lock loss overrides everything; counters fall back to zero outside RUN
  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = '0;
    h_nxt        = '0;
    v_nxt        = '0;
    if (!lock_s) begin
      state_nxt = WAIT_LOCK;
    end else begin
      case (state)
        WAIT_LOCK: begin
          if (lock_cnt == LOCK_LAST) state_nxt = IDLE;
          else                       lock_cnt_nxt = lock_cnt + 1'b1;
        end
        IDLE: begin
          if (i_en) state_nxt = RUN;
        end
        RUN: begin
          h_nxt = h_last ? 11'd0 : h + 11'd1;
          v_nxt = h_last ? (v_last ? 11'd0 : v + 11'd1) : v;
          if (!i_en && h_last && v_last) state_nxt = IDLE;
        end
        default: state_nxt = WAIT_LOCK;
      endcase
    end
  end

  // Decode the upcoming (h, v) so the registered outputs describe the current position
  always_comb begin
    run_nxt = (state_nxt == RUN);
    de_nxt  = run_nxt && ({1'b0, h_nxt} < H_ACT_C) && ({1'b0, v_nxt} < V_ACT_C);
    hs_act  = run_nxt && ({1'b0, h_nxt} >= HS_BEG_C) && ({1'b0, h_nxt} < HS_END_C);
    vs_act  = run_nxt && ({1'b0, v_nxt} >= VS_BEG_C) && ({1'b0, v_nxt} < VS_END_C);
    sol_nxt = run_nxt && (h_nxt == 11'd0);
    sof_nxt = sol_nxt && (v_nxt == 11'd0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_run   <= 1'b0;
      o_de    <= 1'b0;
      o_hsync <= ~HP;
      o_vsync <= ~VP;
      o_x     <= '0;
      o_y     <= '0;
      o_sof   <= 1'b0;
      o_sol   <= 1'b0;
    end else begin
      o_run   <= run_nxt;
      o_de    <= de_nxt;
      o_hsync <= hs_act ? HP : ~HP;
      o_vsync <= vs_act ? VP : ~VP;
      o_x     <= h_nxt;
      o_y     <= v_nxt;
      o_sof   <= sof_nxt;
      o_sol   <= sol_nxt;
    end
  end

`ifdef VIDEO_TIMING_GEN_PREFETCH_EN
  // Combinational look-ahead so the IDLE->RUN cycle can already request pixel (0,0)
  assign o_req = !i_rst && de_nxt;
  assign o_nx  = i_rst ? 11'd0 : h_nxt;
  assign o_ny  = i_rst ? 11'd0 : v_nxt;
`endif

endmodule
